store_narrow_buffer: RTL and testbench

MEM-stage store path for the pipelined MIPS core. It narrows and aligns register store data for `sw`, `sh` and `sb`, and generates per-byte write enables. Accepted stores are held in a small in-order FIFO and drained to data memory over a valid/ready handshake. It is the write-side counterpart of the load extender: that block widens memory data into a register, and this block narrows register data into memory.

---
 rtl/store_narrow_buffer.sv | 117 +++++++++++
 tb/tb_store_narrow_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_buffer.sv
// Store path for the MEM stage: narrows and aligns sw/sh/sb data, builds byte
// enables, and queues accepted stores in an in-order FIFO that drains to data
// memory over a valid/ready handshake.
module store_narrow_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          good;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic          accept;
  logic          push;
  logic          pop;

  assign st_ready  = (count != CNT_FULL);
  assign mem_valid = (count != '0);
  assign empty     = (count == '0);
  assign accept    = st_valid & st_ready;
  assign push      = accept & good;
  assign pop       = mem_valid & mem_ready;

  // Decode the store width: alignment check, lane enables and lane-replicated data.
  always_comb begin
    good      = 1'b0;
    be_new    = 4'b0000;
    wdata_new = 32'h0;
    case (st_op)
      2'b00: begin
        good      = (st_addr[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = st_data;
      end
      2'b01: begin
        good      = ~st_addr[0];
        be_new    = st_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{st_data[15:0]}};
      end
      2'b10: begin
        good      = 1'b1;
        be_new    = 4'b0001 << st_addr[1:0];
        wdata_new = {4{st_data[7:0]}};
      end
      default: begin
        good = 1'b0;
      end
    endcase
  end

  // FIFO storage: data lanes carry no reset, only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr]  <= {st_addr[31:2], 2'b00};
      wdata_q[wr_ptr] <= wdata_new;
      be_q[wr_ptr]    <= be_new;
    end
  end

  // Pointers, occupancy and the one-cycle error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= accept & ~good;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Present the head entry, forced to zero while nothing is queued.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (mem_valid) begin
      mem_addr  = addr_q[rd_ptr];
      mem_wdata = wdata_q[rd_ptr];
      mem_be    = be_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Bench for store_narrow_buffer: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_store_narrow_buffer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;

  store_narrow_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_op(st_op),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_err(st_err),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
  } ent_t;

  ent_t q[$];
  logic err_exp;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's current state.
  task automatic check_outputs(input string ctx);
    ent_t h;
    h.a = 32'h0; h.w = 32'h0; h.b = 4'h0;
    if (q.size() != 0) h = q[0];
    chk({ctx, ".mem_valid"}, 32'(mem_valid), 32'(q.size() != 0));
    chk({ctx, ".st_ready"},  32'(st_ready),  32'(q.size() != DEPTH));
    chk({ctx, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({ctx, ".st_err"},    32'(st_err),    32'(err_exp));
    chk({ctx, ".mem_addr"},  mem_addr,       h.a);
    chk({ctx, ".mem_wdata"}, mem_wdata,      h.w);
    chk({ctx, ".mem_be"},    32'(mem_be),    32'(h.b));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic r, input string ctx);
    bit   acc;
    bit   pop;
    bit   ok;
    int   lane;
    ent_t e;
    st_valid  = v;
    st_op     = op;
    st_addr   = a;
    st_data   = d;
    mem_ready = r;
    lane = int'(a % 4);
    e.a = a - (a % 4);
    e.w = 32'h0;
    e.b = 4'h0;
    ok  = 1'b0;
    if (op == 2'd0) begin
      ok = (lane == 0); e.b = 4'hF; e.w = d;
    end else if (op == 2'd1) begin
      ok = (lane % 2 == 0); e.b = 4'(3 << lane); e.w = (d & 32'hFFFF) * 32'h0001_0001;
    end else if (op == 2'd2) begin
      ok = 1'b1; e.b = 4'(1 << lane); e.w = (d & 32'hFF) * 32'h0101_0101;
    end
    acc = v && (q.size() != DEPTH);
    pop = (q.size() != 0) && r;
    err_exp = acc && !ok;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && ok) q.push_back(e);
    @(negedge clk);
    check_outputs(ctx);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    err_exp = 1'b0;
    reset_n = 1'b0;
    st_valid = 1'b0;
    st_op = 2'b00;
    st_addr = 32'h0;
    st_data = 32'h0;
    mem_ready = 1'b0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Word store drains the next cycle.
    step(1'b1, 2'd0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, "sw");
    chk("sw.addr_const",  mem_addr,  32'h0000_1004);
    chk("sw.wdata_const", mem_wdata, 32'hDEAD_BEEF);
    chk("sw.be_const",    32'(mem_be), 32'hF);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "sw_drain");
    chk("sw.empty_after", 32'(empty), 32'h1);

    // Byte and half lane placement.
    step(1'b1, 2'd2, 32'h0000_1003, 32'h1234_56AB, 1'b1, "sb");
    chk("sb.wdata_const", mem_wdata, 32'hABAB_ABAB);
    chk("sb.be_const",    32'(mem_be), 32'h8);
    chk("sb.addr_const",  mem_addr,  32'h0000_1000);
    step(1'b1, 2'd1, 32'h0000_2002, 32'h0000_C0DE, 1'b1, "sh");
    chk("sh.wdata_const", mem_wdata, 32'hC0DE_C0DE);
    chk("sh.be_const",    32'(mem_be), 32'hC);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "sh_drain");

    // Misaligned and reserved requests, back to back.
    step(1'b1, 2'd1, 32'h0000_2001, 32'h1111_1111, 1'b1, "bad_sh");
    chk("bad_sh.err_const", 32'(st_err), 32'h1);
    step(1'b1, 2'd0, 32'h0000_2002, 32'h2222_2222, 1'b1, "bad_sw");
    chk("bad_sw.err_const", 32'(st_err), 32'h1);
    step(1'b1, 2'd3, 32'h0000_2000, 32'h3333_3333, 1'b1, "bad_op");
    chk("bad_op.err_const", 32'(st_err), 32'h1);
    chk("bad_op.valid_const", 32'(mem_valid), 32'h0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "bad_clear");
    chk("bad_clear.err_const", 32'(st_err), 32'h0);

    // Fill with memory stalled, hold, then drain with the third waiting.
    step(1'b1, 2'd2, 32'h0000_3000, 32'h0000_0011, 1'b0, "fill0");
    step(1'b1, 2'd2, 32'h0000_3001, 32'h0000_0022, 1'b0, "fill1");
    chk("fill.ready_const", 32'(st_ready), 32'h0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'd2, 32'h0000_3002, 32'h0000_0033, 1'b0, "hold");
    chk("hold.wdata_const", mem_wdata, 32'h1111_1111);
    step(1'b1, 2'd2, 32'h0000_3002, 32'h0000_0033, 1'b1, "pop0");
    chk("pop0.ready_const", 32'(st_ready), 32'h1);
    step(1'b1, 2'd2, 32'h0000_3002, 32'h0000_0033, 1'b1, "pop1");
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "pop2");
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "pop_idle");

    // Steady word stream at full rate.
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'd0, 32'h0000_5000 + 32'(i * 4), $urandom, 1'b1, "stream");
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "stream_end");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           $urandom, 1'($urandom_range(0, 9) < 6), "rand");

    // Asynchronous reset with two entries queued.
    step(1'b1, 2'd0, 32'h0000_4000, 32'hAAAA_0001, 1'b0, "pre_rst0");
    step(1'b1, 2'd0, 32'h0000_4004, 32'hAAAA_0002, 1'b0, "pre_rst1");
    chk("pre_rst.valid_const", 32'(mem_valid), 32'h1);
    st_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    err_exp = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs("rst_release");
    step(1'b1, 2'd0, 32'h0000_6008, 32'h0BAD_F00D, 1'b1, "post_rst_sw");
    chk("post_rst.wdata_const", mem_wdata, 32'h0BAD_F00D);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
